button_debouncer: RTL and testbench



---
 rtl/button_debouncer.sv | 206 ++++++++++++++++++++
 tb/tb_button_debouncer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns one raw, asynchronous push-button pin into clean, clk-synchronous
// control signals: a debounced level, one-cycle press/release pulses, an
// optional auto-repeat tick while the button is held, and a combined "step"
// strobe (press or repeat).
//
// Parameters:
//   SYNC_STAGES   - synchroniser depth (>= 2)
//   ACTIVE_LOW    - 1 when the pin reads 0 while pressed
//   DEBOUNCE      - consecutive disagreeing samples needed to change state (>= 1)
//   REPEAT_DELAY  - cycles from press to first repeat, 0 disables auto-repeat
//   REPEAT_PERIOD - cycles between subsequent repeats (>= 1)
//
// Ports:
//   clk           in  design clock, all flops on its rising edge
//   resetn        in  synchronous active-low reset
//   btn           in  raw button pin
//   pressed       out debounced level, 1 while held
//   press_pulse   out one-cycle pulse per debounced press
//   release_pulse out one-cycle pulse per debounced release
//   repeat_pulse  out one-cycle pulse per auto-repeat tick
//   step          out press_pulse | repeat_pulse
//
// Every output comes straight from a flop; nothing combinational reaches a pin.
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0,
    parameter int DEBOUNCE      = 50000,
    parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 1200000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step
);

    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE - 1);
    // With auto-repeat disabled the DELAY state is unreachable; keep the
    // constant legal anyway.
    localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic          REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic          POLARITY    = (ACTIVE_LOW != 0);

    // -------------------------------------------------------------------------
    // Synchroniser: polarity is folded in before the first flop so every stage
    // resets to "not pressed" regardless of ACTIVE_LOW.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = btn ^ POLARITY;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    logic s;
    assign s = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce: count consecutive samples that disagree with the current
    // debounced level; any agreeing sample restarts the count.
    // -------------------------------------------------------------------------
    logic [DW-1:0] dcnt_reg;
    logic [DW-1:0] dcnt_next;
    logic          pressed_reg;
    logic          pressed_next;
    logic          press_evt;
    logic          release_evt;

    always_comb begin
        dcnt_next    = dcnt_reg;
        pressed_next = pressed_reg;
        press_evt    = 1'b0;
        release_evt  = 1'b0;
        if (s == pressed_reg) begin
            dcnt_next = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
            dcnt_next    = '0;
            pressed_next = s;
            press_evt    = s;
            release_evt  = ~s;
        end else begin
            dcnt_next = dcnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Auto-repeat FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [RW-1:0] rcnt_reg;
    logic [RW-1:0] rcnt_next;
    logic          repeat_evt;

    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        repeat_evt = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                rcnt_next = '0;
                if (press_evt && REPEAT_EN) begin
                    state_next = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (rcnt_reg == DELAY_LAST) begin
                    repeat_evt = 1'b1;
                    state_next = ST_REPEAT;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (rcnt_reg == PERIOD_LAST) begin
                    repeat_evt = 1'b1;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                rcnt_next  = '0;
            end
        endcase
        // A release beats a repeat tick landing on the same edge.
        if (release_evt) begin
            state_next = ST_IDLE;
            rcnt_next  = '0;
            repeat_evt = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    logic press_pulse_reg;
    logic release_pulse_reg;
    logic repeat_pulse_reg;
    logic step_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dcnt_reg          <= '0;
            pressed_reg       <= 1'b0;
            state_reg         <= ST_IDLE;
            rcnt_reg          <= '0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            repeat_pulse_reg  <= 1'b0;
            step_reg          <= 1'b0;
        end else begin
            dcnt_reg          <= dcnt_next;
            pressed_reg       <= pressed_next;
            state_reg         <= state_next;
            rcnt_reg          <= rcnt_next;
            press_pulse_reg   <= press_evt;
            release_pulse_reg <= release_evt;
            repeat_pulse_reg  <= repeat_evt;
            step_reg          <= press_evt | repeat_evt;
        end
    end

    assign pressed       = pressed_reg;
    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
    assign repeat_pulse  = repeat_pulse_reg;
    assign step          = step_reg;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Two instances share clk/resetn: one
// active-high (btn) and one active-low (btn_al). After every rising edge both
// instances' outputs are compared, packed as
// {pressed, press_pulse, release_pulse, repeat_pulse, step}.
// Edge n=0 of a run is the first edge that samples the active pin, so the
// press edge is n=5; a release whose first sampled inactive edge is r lands
// at r+5. Repeats fall 10, 13, 16, ... edges after the press edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    logic clk;
    logic resetn;
    logic btn;
    logic btn_al;

    logic pressed_m, press_pulse_m, release_pulse_m, repeat_pulse_m, step_m;
    logic pressed_a, press_pulse_a, release_pulse_a, repeat_pulse_a, step_a;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .SYNC_STAGES  (2),
        .ACTIVE_LOW   (0),
        .DEBOUNCE     (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .btn          (btn),
        .pressed      (pressed_m),
        .press_pulse  (press_pulse_m),
        .release_pulse(release_pulse_m),
        .repeat_pulse (repeat_pulse_m),
        .step         (step_m)
    );

    button_debouncer #(
        .SYNC_STAGES  (2),
        .ACTIVE_LOW   (1),
        .DEBOUNCE     (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut_al (
        .clk          (clk),
        .resetn       (resetn),
        .btn          (btn_al),
        .pressed      (pressed_a),
        .press_pulse  (press_pulse_a),
        .release_pulse(release_pulse_a),
        .repeat_pulse (repeat_pulse_a),
        .step         (step_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a press whose first active sample is edge 0 and
    // whose first inactive sample is edge rel.
    function automatic logic [4:0] exp_run(input int n, input int rel);
        logic held, pp, rp, rep;
        held = (n >= 5) && (n < rel + 5);
        pp   = (n == 5);
        rp   = (n == rel + 5);
        rep  = held && (n - 5 >= 10) && (((n - 15) % 3) == 0);
        return {held, pp, rp, rep, pp | rep};
    endfunction

    // Advance one edge, then compare both instances.
    task automatic cyc(input string tag, input logic [4:0] exp_m, input logic [4:0] exp_a);
        logic [4:0] obs_m, obs_a;
        @(posedge clk);
        #1;
        obs_m = {pressed_m, press_pulse_m, release_pulse_m, repeat_pulse_m, step_m};
        obs_a = {pressed_a, press_pulse_a, release_pulse_a, repeat_pulse_a, step_a};
        $display("%s: main=%b al=%b", tag, obs_m, obs_a);
        checks++;
        assert (obs_m === exp_m)
        else begin
            errors++;
            $error("FAIL %s main observed=%b expected=%b", tag, obs_m, exp_m);
        end
        checks++;
        assert (obs_a === exp_a)
        else begin
            errors++;
            $error("FAIL %s al observed=%b expected=%b", tag, obs_a, exp_a);
        end
    endtask

    // Press one instance's pin from edge 0, release it from edge rel; the other
    // instance stays idle.
    task automatic run(input string tag, input bit use_al, input int rel, input int total);
        for (int n = 0; n <= total; n++) begin
            if (use_al) btn_al = (n < rel) ? 1'b0 : 1'b1;
            else        btn    = (n < rel);
            if (use_al) cyc($sformatf("%s n=%0d", tag, n), 5'b00000, exp_run(n, rel));
            else        cyc($sformatf("%s n=%0d", tag, n), exp_run(n, rel), 5'b00000);
        end
    endtask

    task automatic idle(input string tag, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            cyc($sformatf("%s n=%0d", tag, n), 5'b00000, 5'b00000);
        end
    endtask

    initial begin
        logic [4:0] e;
        int         p;
        btn    = 1'b0;
        btn_al = 1'b1;
        resetn = 1'b0;

        // Reset state, then idle with the active-low pin sitting high.
        idle("reset", 3);
        resetn = 1'b1;
        idle("idle", 4);

        // Clean press held past several repeats; release lands on P+28,
        // which coincides with a repeat tick.
        run("hold", 1'b0, 28, 36);
        idle("after_hold", 4);

        // Single 4-cycle glitch: exactly one press and one release.
        run("glitch4", 1'b0, 4, 12);
        idle("after_glitch", 3);

        // Bounce: 3 high / 1 low for 40 cycles never debounces.
        for (int n = 0; n < 48; n++) begin
            btn = (n < 40) && ((n % 4) != 3);
            cyc($sformatf("bounce n=%0d", n), 5'b00000, 5'b00000);
        end

        // Release edge equals P+13, where a repeat would otherwise fire.
        run("collide", 1'b0, 13, 22);
        idle("after_collide", 8);

        // Reset for two edges at P+12 while held; fresh press 5 edges after
        // the first edge with resetn high (edge 19 -> press at 24).
        for (int n = 0; n <= 44; n++) begin
            btn    = (n < 37);
            resetn = !((n == 17) || (n == 18));
            if (n < 5 || (n >= 17 && n < 24) || n > 42) begin
                e = 5'b00000;
            end else if (n == 42) begin
                e = 5'b00100;
            end else begin
                p = (n < 17) ? 5 : 24;
                e = {1'b1, (n == p), 1'b0,
                     ((n - p >= 10) && (((n - p - 10) % 3) == 0)),
                     ((n == p) || ((n - p >= 10) && (((n - p - 10) % 3) == 0)))};
            end
            cyc($sformatf("rst_hold n=%0d", n), e, 5'b00000);
        end
        resetn = 1'b1;
        idle("after_rst", 3);

        // Active-low instance: drive pin low, press after edge 5.
        run("polarity", 1'b1, 6, 14);
        idle("after_pol", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
